cpu_seq_ctrl: RTL

- Instruction sequencer for the accumulator CPU. Owns the 8-bit program counter and drives the instruction decoder's address.
- Registers the decoded fields (mode, short op, long op, operand address) and walks a fetch/execute state machine.
- Issues one-cycle strobes to the accumulator/ALU and a req/ack handshake to data memory.
- Sits between the instruction decoder, the accumulator datapath and the data RAM.

---
 rtl/cpu_seq_ctrl_pkg.sv | 62 ++++++
 rtl/cpu_seq_ctrl_if.sv | 24 ++
 rtl/cpu_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types for the accumulator CPU sequencer:
// FSM states, opcode encodings and the opcode classifier.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } state_e;

  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_CLA = 3'b011;
  localparam logic [2:0] OP_COM = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_BAN = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_CSL = 4'b1110;
  localparam logic [3:0] OP_STP = 4'b1111;

  typedef enum logic [3:0] {
    K_ILL,
    K_STA,
    K_LDA,
    K_CLA,
    K_COM,
    K_JMP,
    K_ADD,
    K_BAN,
    K_SHR,
    K_CSL,
    K_STP
  } kind_e;

  function automatic kind_e op_kind(
    input logic       mode,
    input logic [2:0] s,
    input logic [3:0] l
  );
    kind_e k;
    k = K_ILL;
    unique case (1'b1)
      !mode && s == OP_STA: k = K_STA;
      !mode && s == OP_LDA: k = K_LDA;
      !mode && s == OP_CLA: k = K_CLA;
      !mode && s == OP_COM: k = K_COM;
      !mode && s == OP_JMP: k = K_JMP;
      mode && l == OP_ADD:  k = K_ADD;
      mode && l == OP_BAN:  k = K_BAN;
      mode && l == OP_SHR:  k = K_SHR;
      mode && l == OP_CSL:  k = K_CSL;
      mode && l == OP_STP:  k = K_STP;
      default:              k = K_ILL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Data-memory req/ack bus between the sequencer
// and the data RAM.
interface cpu_seq_ctrl_if #(
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ack
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Fetch/execute sequencer: owns the PC, latches the
// decoded IR and issues accumulator strobes and memory requests.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic            ins_mode,
  input  logic [2:0]      ins_short,
  input  logic [3:0]      ins_long,
  input  logic [PC_W-1:0] data_addr,
  input  logic            acc_neg,
  output logic            acc_clr,
  output logic            acc_com,
  output logic            acc_csl,
  output logic            acc_shr,
  output logic            acc_ld,
  output logic            alu_add,
  cpu_seq_ctrl_if.master  mem,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_e          state;
  logic            ir_mode;
  logic [2:0]      ir_short;
  logic [3:0]      ir_long;
  logic [PC_W-1:0] ir_addr;
  kind_e           kind;

  assign kind   = op_kind(ir_mode, ir_short, ir_long);
  assign busy   = (state == FETCH) || (state == EXEC)
               || (state == MEM);
  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ir_mode      <= 1'b0;
      ir_short     <= '0;
      ir_long      <= '0;
      ir_addr      <= '0;
      illegal      <= 1'b0;
      acc_clr      <= 1'b0;
      acc_com      <= 1'b0;
      acc_csl      <= 1'b0;
      acc_shr      <= 1'b0;
      acc_ld       <= 1'b0;
      alu_add      <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      acc_clr <= 1'b0;
      acc_com <= 1'b0;
      acc_csl <= 1'b0;
      acc_shr <= 1'b0;
      acc_ld  <= 1'b0;
      alu_add <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir_mode  <= ins_mode;
          ir_short <= ins_short;
          ir_long  <= ins_long;
          ir_addr  <= data_addr;
          state    <= EXEC;
        end
        EXEC: begin
          unique case (kind)
            K_CLA: begin
              acc_clr <= 1'b1;
              pc      <= pc + 1'b1;
              state   <= FETCH;
            end
            K_COM: begin
              acc_com <= 1'b1;
              pc      <= pc + 1'b1;
              state   <= FETCH;
            end
            K_CSL: begin
              acc_csl <= 1'b1;
              pc      <= pc + 1'b1;
              state   <= FETCH;
            end
            K_SHR: begin
              acc_shr <= 1'b1;
              pc      <= pc + 1'b1;
              state   <= FETCH;
            end
            K_JMP: begin
              pc    <= ir_addr;
              state <= FETCH;
            end
            K_BAN: begin
              pc    <= acc_neg ? ir_addr : pc + 1'b1;
              state <= FETCH;
            end
            K_LDA, K_ADD, K_STA: begin
              mem.mem_req  <= 1'b1;
              mem.mem_we   <= (kind == K_STA);
              mem.mem_addr <= ir_addr;
              state        <= MEM;
            end
            K_STP: state <= HALT;
            default: begin
              illegal <= 1'b1;
              state   <= HALT;
            end
          endcase
        end
        MEM: begin
          if (mem.mem_ack) begin
            acc_ld      <= (kind == K_LDA);
            alu_add     <= (kind == K_ADD);
            pc          <= pc + 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT: begin
          if (start) begin
            pc      <= RESET_PC;
            illegal <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
